stack_return_unit: RTL and testbench

- Stack-pop sequencer for RET and RTI in the pipelined RISC core; the reader side of the push path that saves PC and flags on CALL/INT.
- Issues consecutive pop requests to the memory stage and collects the 16-bit words returned on the memory stage's registered read-data output.
- Reassembles the 32-bit return PC (plus the 3-bit flags for RTI) and presents them to fetch and the flag register as single-cycle load pulses.
- Stalls the front end while busy.

---
 rtl/stack_return_unit_pkg.sv | 29 ++
 rtl/stack_return_unit_var_reg.sv | 20 ++
 rtl/stack_return_unit.sv | 100 ++++++++++
 tb/tb_stack_return_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/stack_return_unit_pkg.sv
// Shared definitions for the stack-pop (RET/RTI) sequencer and its push-side counterpart.
// Covers word widths, stack word order and the sequencer state encoding.
package stack_return_unit_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int FLAG_W = 3;

  // Pops come back in the reverse order of the CALL/INT pushes.
  localparam int POP_SLOT_PC_LO = 0;
  localparam int POP_SLOT_PC_HI = 1;
  localparam int POP_SLOT_FLAGS = 2;
  localparam int RET_POP_WORDS  = 2;
  localparam int RTI_POP_WORDS  = 3;

  typedef enum logic [2:0] {
    IDLE,
    POP_LO,
    POP_HI,
    POP_FL,
    DRAIN,
    LOAD
  } ret_state_t;

  function automatic logic is_pop_state(input ret_state_t s);
    return (s == POP_LO) || (s == POP_HI) || (s == POP_FL);
  endfunction

endpackage

// File: rtl/stack_return_unit_var_reg.sv
// Size-parameterised register with write enable and synchronous active-low clear.
module var_reg #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stack_return_unit.sv
// RET/RTI stack-pop sequencer: pops PC low, PC high and (RTI) flags, then pulses the loads.
// Read data arrives one cycle after each pop, so every capture lags its pop by one state.
module stack_return_unit #(
  parameter int DATA_W = stack_return_unit_pkg::DATA_W,
  parameter int PC_W   = stack_return_unit_pkg::PC_W,
  parameter int FLAG_W = stack_return_unit_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_ret,
  input  logic              start_rti,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_pop,
  output logic              busy,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load
);

  import stack_return_unit_pkg::*;

  ret_state_t state;
  ret_state_t next_state;
  logic       is_rti;
  logic       next_is_rti;
  logic       we_pc_lo;
  logic       we_pc_hi;
  logic       we_flags;

  always_comb begin
    next_state  = state;
    next_is_rti = is_rti;
    case (state)
      IDLE: begin
        if (start_rti) begin
          next_state  = POP_LO;
          next_is_rti = 1'b1;
        end else if (start_ret) begin
          next_state  = POP_LO;
          next_is_rti = 1'b0;
        end
      end
      POP_LO:  next_state = POP_HI;
      POP_HI:  next_state = is_rti ? POP_FL : DRAIN;
      POP_FL:  next_state = DRAIN;
      DRAIN:   next_state = LOAD;
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      is_rti     <= 1'b0;
      mem_pop    <= 1'b0;
      busy       <= 1'b0;
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
    end else begin
      state      <= next_state;
      is_rti     <= next_is_rti;
      mem_pop    <= is_pop_state(next_state);
      busy       <= (next_state != IDLE);
      pc_load    <= (next_state == LOAD);
      flags_load <= (next_state == LOAD) && next_is_rti;
    end
  end

  assign we_pc_lo = (state == POP_HI);
  assign we_pc_hi = (state == POP_FL) || ((state == DRAIN) && !is_rti);
  assign we_flags = (state == DRAIN) && is_rti;

  var_reg #(.SIZE(DATA_W)) u_pc_lo (
    .clk   (clk),
    .reset (reset),
    .en    (we_pc_lo),
    .d     (mem_data_in),
    .q     (pc_out[DATA_W-1:0])
  );

  var_reg #(.SIZE(PC_W - DATA_W)) u_pc_hi (
    .clk   (clk),
    .reset (reset),
    .en    (we_pc_hi),
    .d     (mem_data_in),
    .q     (pc_out[PC_W-1:DATA_W])
  );

  var_reg #(.SIZE(FLAG_W)) u_flags (
    .clk   (clk),
    .reset (reset),
    .en    (we_flags),
    .d     (mem_data_in[FLAG_W-1:0]),
    .q     (flags_out)
  );

endmodule

// File: tb/tb_stack_return_unit.sv
// Scoreboard bench for stack_return_unit: directed steps queue expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_stack_return_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_ret;
  logic        start_rti;
  logic [15:0] mem_data_in;
  logic        mem_pop;
  logic        busy;
  logic [31:0] pc_out;
  logic        pc_load;
  logic [2:0]  flags_out;
  logic        flags_load;

  typedef struct {
    logic        pop;
    logic        busy;
    logic        pl;
    logic        fl;
    logic [31:0] pc;
    logic [2:0]  flags;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  localparam logic [15:0] DC = 16'hC3C3;

  always #5 clk = ~clk;

  stack_return_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start_ret   (start_ret),
    .start_rti   (start_rti),
    .mem_data_in (mem_data_in),
    .mem_pop     (mem_pop),
    .busy        (busy),
    .pc_out      (pc_out),
    .pc_load     (pc_load),
    .flags_out   (flags_out),
    .flags_load  (flags_load)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive inputs for the next edge, clock it, then queue the outputs expected after it.
  task automatic apply_stimulus(input logic s_ret, input logic s_rti, input logic rst_n,
                                input logic [15:0] data, input logic e_pop, input logic e_busy,
                                input logic e_pl, input logic e_fl, input logic [31:0] e_pc,
                                input logic [2:0] e_flags, input string tag);
    exp_t e;
    start_ret   = s_ret;
    start_rti   = s_rti;
    reset       = rst_n;
    mem_data_in = data;
    @(posedge clk);
    #1;
    e.pop   = e_pop;
    e.busy  = e_busy;
    e.pl    = e_pl;
    e.fl    = e_fl;
    e.pc    = e_pc;
    e.flags = e_flags;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_output({t, ".mem_pop"},    {31'd0, mem_pop},    {31'd0, e.pop});
        check_output({t, ".busy"},       {31'd0, busy},       {31'd0, e.busy});
        check_output({t, ".pc_load"},    {31'd0, pc_load},    {31'd0, e.pl});
        check_output({t, ".flags_load"}, {31'd0, flags_load}, {31'd0, e.fl});
        check_output({t, ".pc_out"},     pc_out,              e.pc);
        check_output({t, ".flags_out"},  {29'd0, flags_out},  {29'd0, e.flags});
      end
    end
  end

  initial begin : stimulus
    start_ret   = 1'b0;
    start_rti   = 1'b0;
    reset       = 1'b0;
    mem_data_in = 16'h0000;

    for (int i = 0; i < 3; i++)
      apply_stimulus(0, 0, 0, DC, 0, 0, 0, 0, 32'h0, 3'd0, "reset");

    // RET: low word during POP_HI, high word during DRAIN
    apply_stimulus(1, 0, 1, DC,       1, 1, 0, 0, 32'h00000000, 3'd0, "ret_c1");
    apply_stimulus(0, 0, 1, DC,       1, 1, 0, 0, 32'h00000000, 3'd0, "ret_c2");
    apply_stimulus(0, 0, 1, 16'h5678, 0, 1, 0, 0, 32'h00005678, 3'd0, "ret_c3");
    apply_stimulus(0, 0, 1, 16'h1234, 0, 1, 1, 0, 32'h12345678, 3'd0, "ret_c4");
    apply_stimulus(0, 0, 1, 16'h9999, 0, 0, 0, 0, 32'h12345678, 3'd0, "ret_c5");

    for (int i = 0; i < 10; i++)
      apply_stimulus(0, 0, 1, (i % 2 == 0) ? 16'hFFFF : 16'h0000,
                     0, 0, 0, 0, 32'h12345678, 3'd0, "hold");

    // RTI: low, high, flags
    apply_stimulus(0, 1, 1, DC,       1, 1, 0, 0, 32'h12345678, 3'd0, "rti_c1");
    apply_stimulus(0, 0, 1, DC,       1, 1, 0, 0, 32'h12345678, 3'd0, "rti_c2");
    apply_stimulus(0, 0, 1, 16'hBEEF, 1, 1, 0, 0, 32'h1234BEEF, 3'd0, "rti_c3");
    apply_stimulus(0, 0, 1, 16'hDEAD, 0, 1, 0, 0, 32'hDEADBEEF, 3'd0, "rti_c4");
    apply_stimulus(0, 0, 1, 16'h0005, 0, 1, 1, 1, 32'hDEADBEEF, 3'd5, "rti_c5");
    apply_stimulus(0, 0, 1, DC,       0, 0, 0, 0, 32'hDEADBEEF, 3'd5, "rti_c6");

    // Both starts together: RTI wins; upper flag-word bits ignored
    apply_stimulus(1, 1, 1, DC,       1, 1, 0, 0, 32'hDEADBEEF, 3'd5, "both_c1");
    apply_stimulus(0, 0, 1, DC,       1, 1, 0, 0, 32'hDEADBEEF, 3'd5, "both_c2");
    apply_stimulus(0, 0, 1, 16'h1111, 1, 1, 0, 0, 32'hDEAD1111, 3'd5, "both_c3");
    apply_stimulus(0, 0, 1, 16'h2222, 0, 1, 0, 0, 32'h22221111, 3'd5, "both_c4");
    apply_stimulus(0, 0, 1, 16'hFFFA, 0, 1, 1, 1, 32'h22221111, 3'd2, "both_c5");
    apply_stimulus(0, 0, 1, DC,       0, 0, 0, 0, 32'h22221111, 3'd2, "both_c6");

    // RET with starts re-pulsed in POP_HI, DRAIN and LOAD: all ignored
    apply_stimulus(1, 0, 1, DC,       1, 1, 0, 0, 32'h22221111, 3'd2, "ign_c1");
    apply_stimulus(0, 0, 1, DC,       1, 1, 0, 0, 32'h22221111, 3'd2, "ign_c2");
    apply_stimulus(1, 0, 1, 16'hAAAA, 0, 1, 0, 0, 32'h2222AAAA, 3'd2, "ign_c3");
    apply_stimulus(1, 0, 1, 16'h5555, 0, 1, 1, 0, 32'h5555AAAA, 3'd2, "ign_c4");
    apply_stimulus(1, 0, 1, DC,       0, 0, 0, 0, 32'h5555AAAA, 3'd2, "ign_c5");

    // Start held into the IDLE cycle after LOAD: accepted
    apply_stimulus(1, 0, 1, DC,       1, 1, 0, 0, 32'h5555AAAA, 3'd2, "b2b_c1");
    apply_stimulus(0, 0, 1, DC,       1, 1, 0, 0, 32'h5555AAAA, 3'd2, "b2b_c2");
    apply_stimulus(0, 0, 1, 16'h0001, 0, 1, 0, 0, 32'h55550001, 3'd2, "b2b_c3");
    apply_stimulus(0, 0, 1, 16'h8000, 0, 1, 1, 0, 32'h80000001, 3'd2, "b2b_c4");
    apply_stimulus(0, 0, 1, DC,       0, 0, 0, 0, 32'h80000001, 3'd2, "b2b_c5");

    // Reset during POP_FL abandons the RTI
    apply_stimulus(0, 1, 1, DC,       1, 1, 0, 0, 32'h80000001, 3'd2, "rst_c1");
    apply_stimulus(0, 0, 1, DC,       1, 1, 0, 0, 32'h80000001, 3'd2, "rst_c2");
    apply_stimulus(0, 0, 1, 16'h3333, 1, 1, 0, 0, 32'h80003333, 3'd2, "rst_c3");
    apply_stimulus(0, 0, 0, 16'h4444, 0, 0, 0, 0, 32'h00000000, 3'd0, "rst_c4");
    for (int i = 0; i < 6; i++)
      apply_stimulus(0, 0, 1, 16'h7777, 0, 0, 0, 0, 32'h00000000, 3'd0, "rst_idle");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
